conv_row_scheduler: RTL

- Sequences one binary 3x3 convolution job.
- Reads the input-SRAM header (rows at addr 0, cols at addr 1) and the weight-memory header (kernel dim at addr 1, packed 9-bit kernel at addr 2).
- Streams a sliding 3-row window of 16-bit input rows to the convolution datapath over a valid/ready handshake, tagging each window with its output-SRAM row address.
- Sits between the top-level run/busy interface and the conv datapath; owns both SRAM read ports.

---
 rtl/conv_row_scheduler_pkg.sv | 37 +++
 rtl/conv_row_scheduler_row_window_buffer.sv | 73 +++++++
 rtl/conv_row_scheduler.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/conv_row_scheduler_pkg.sv
// Shared constants, state encoding and header validation for the
// 3x3 binary convolution row scheduler.
package conv_row_scheduler_pkg;

    localparam int          CRS_ADDR_W      = 12;
    localparam int          CRS_DATA_W      = 16;
    localparam int          CRS_KDIM        = 3;
    localparam logic [11:0] CRS_IN_BASE     = 12'h0;
    localparam logic [11:0] CRS_W_DIM_ADDR  = 12'h1;
    localparam logic [11:0] CRS_W_DATA_ADDR = 12'h2;

    // Row limit keeps the last row address (IN_BASE+1+nrows) inside 12 bits.
    localparam int          CRS_MIN_DIM     = 3;
    localparam int          CRS_MAX_ROWS    = 4094;
    localparam int          CRS_MAX_COLS    = 16;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_HDR0    = 3'd1;
    localparam state_t S_HDR1    = 3'd2;
    localparam state_t S_FILL    = 3'd3;
    localparam state_t S_PRESENT = 3'd4;
    localparam state_t S_DONE    = 3'd5;

    // Header is usable only for a square kernel of the supported size and
    // an image large enough to hold at least one 3x3 window.
    function automatic logic hdr_ok(input logic [15:0] nrows,
                                    input logic [15:0] ncols,
                                    input logic [15:0] kdim,
                                    input logic [15:0] kdim_req);
        return (kdim == kdim_req)
            && (nrows >= 16'(CRS_MIN_DIM)) && (nrows <= 16'(CRS_MAX_ROWS))
            && (ncols >= 16'(CRS_MIN_DIM)) && (ncols <= 16'(CRS_MAX_COLS));
    endfunction

endpackage

// File: rtl/conv_row_scheduler_row_window_buffer.sv
// Three-row sliding window plus a one-row staging register. Rows enter at
// the bottom (r2) and move toward the top (r0). A row that returns from the
// SRAM while the window is stalled parks in the staging register; if the
// window advances in the same cycle the row returns, it bypasses straight
// into r2.
module row_window_buffer
    import conv_row_scheduler_pkg::*;
#(
    parameter int DATA_W = CRS_DATA_W
)(
    input  logic              clk,
    input  logic              reset_b,
    input  logic              i_clear,
    input  logic              i_fill,
    input  logic              i_accept,
    input  logic              i_rd_valid,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic [DATA_W-1:0] o_r0,
    output logic [DATA_W-1:0] o_r1,
    output logic [DATA_W-1:0] o_r2
);

    logic [DATA_W-1:0] r_row0;
    logic [DATA_W-1:0] r_row1;
    logic [DATA_W-1:0] r_row2;
    logic [DATA_W-1:0] r_stage;
    logic              r_stage_valid;

    // Window shift, staging capture and bypass into the bottom row.
    // NOTE: every register here is assigned with <= so all of them update
    // from the same pre-edge values and the shift chain does not collapse.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_row0        <= '0;
            r_row1        <= '0;
            r_row2        <= '0;
            r_stage       <= '0;
            r_stage_valid <= 1'b0;
        end else if (i_clear) begin
            r_row0        <= '0;
            r_row1        <= '0;
            r_row2        <= '0;
            r_stage       <= '0;
            r_stage_valid <= 1'b0;
        end else if (i_fill) begin
            if (i_rd_valid) begin
                r_row0 <= r_row1;
                r_row1 <= r_row2;
                r_row2 <= i_rd_data;
            end
        end else if (i_accept) begin
            r_row0 <= r_row1;
            r_row1 <= r_row2;
            if (r_stage_valid) begin
                r_row2        <= r_stage;
                r_stage_valid <= i_rd_valid;
                if (i_rd_valid) begin
                    r_stage <= i_rd_data;
                end
            end else if (i_rd_valid) begin
                r_row2 <= i_rd_data;
            end
        end else if (i_rd_valid) begin
            r_stage       <= i_rd_data;
            r_stage_valid <= 1'b1;
        end
    end

    assign o_r0 = r_row0;
    assign o_r1 = r_row1;
    assign o_r2 = r_row2;

endmodule

// File: rtl/conv_row_scheduler.sv
// Job sequencer for one binary 3x3 convolution: reads the image and weight
// headers, loads the kernel, then streams a sliding 3-row window to the
// datapath over valid/ready, tagging each window with its output row.
module conv_row_scheduler
    import conv_row_scheduler_pkg::*;
#(
    parameter int                ADDR_W      = CRS_ADDR_W,
    parameter int                DATA_W      = CRS_DATA_W,
    parameter int                KDIM        = CRS_KDIM,
    parameter logic [ADDR_W-1:0] IN_BASE     = CRS_IN_BASE,
    parameter logic [ADDR_W-1:0] W_DIM_ADDR  = CRS_W_DIM_ADDR,
    parameter logic [ADDR_W-1:0] W_DATA_ADDR = CRS_W_DATA_ADDR
)(
    input  logic              clk,
    input  logic              reset_b,
    input  logic              run,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] sram_rd_addr,
    input  logic [DATA_W-1:0] sram_rd_data,
    output logic [ADDR_W-1:0] wmem_rd_addr,
    input  logic [DATA_W-1:0] wmem_rd_data,
    output logic [8:0]        kernel,
    output logic              kern_load,
    output logic [DATA_W-1:0] win_r0,
    output logic [DATA_W-1:0] win_r1,
    output logic [DATA_W-1:0] win_r2,
    output logic [ADDR_W-1:0] win_out_addr,
    output logic              win_last,
    output logic              win_valid,
    input  logic              win_ready
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [15:0]       r_nrows;
    logic [15:0]       r_kdim;
    logic [15:0]       r_rd_row;      // index of the next image row to read
    logic [1:0]        r_fill_cnt;
    logic              r_rd_pending;  // a row read was issued last cycle
    logic              r_kern_load;
    logic              r_err;
    logic [8:0]        r_kernel;
    logic [ADDR_W-1:0] r_out_addr;

    logic              w_start;
    logic              w_hdr_ok;
    logic              w_rows_left;
    logic              w_accept;
    logic              w_last;
    logic              w_issue_row;
    logic [ADDR_W-1:0] w_row_addr;
    logic [ADDR_W-1:0] w_sram_addr;
    logic [ADDR_W-1:0] w_wmem_addr;

    assign w_start     = (r_state == S_IDLE) && run;
    assign w_hdr_ok    = hdr_ok(r_nrows, 16'(sram_rd_data), r_kdim, 16'(KDIM));
    assign w_rows_left = (r_rd_row < r_nrows);
    assign w_accept    = (r_state == S_PRESENT) && win_ready;
    assign w_last      = (r_state == S_PRESENT) && (16'(r_out_addr) == (r_nrows - 16'd3));
    assign w_row_addr  = ADDR_W'(16'(IN_BASE) + 16'd2 + r_rd_row);

    // A row read goes out for the first row once the header passes, for each
    // fill cycle while rows remain, and for each accepted non-final window.
    assign w_issue_row = ((r_state == S_HDR1) && w_hdr_ok)
                      || ((r_state == S_FILL) && w_rows_left)
                      || (w_accept && !w_last && w_rows_left);

    // Next-state decode; run is only looked at in IDLE.
    // NOTE: the default assignment up front keeps this block free of latches.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (run) w_state_nxt = S_HDR0;
            S_HDR0:    w_state_nxt = S_HDR1;
            S_HDR1:    w_state_nxt = w_hdr_ok ? S_FILL : S_DONE;
            S_FILL:    if (r_fill_cnt == 2'd2) w_state_nxt = S_PRESENT;
            S_PRESENT: if (w_accept && w_last) w_state_nxt = S_DONE;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Read-port addressing: header words first, then image rows on demand.
    always_comb begin
        w_sram_addr = '0;
        w_wmem_addr = '0;
        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_sram_addr = IN_BASE;
                    w_wmem_addr = W_DIM_ADDR;
                end
            end
            S_HDR0: begin
                w_sram_addr = IN_BASE + ADDR_W'(1);
                w_wmem_addr = W_DATA_ADDR;
            end
            default: begin
                if (w_issue_row) w_sram_addr = w_row_addr;
            end
        endcase
    end

    // State, header capture, row/window counters and kernel register.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state      <= S_IDLE;
            r_nrows      <= '0;
            r_kdim       <= '0;
            r_rd_row     <= '0;
            r_fill_cnt   <= '0;
            r_rd_pending <= 1'b0;
            r_kern_load  <= 1'b0;
            r_err        <= 1'b0;
            r_kernel     <= '0;
            r_out_addr   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_rd_pending <= w_issue_row;
            r_kern_load  <= (r_state == S_HDR1) && w_hdr_ok;

            if (w_start) begin
                r_rd_row   <= '0;
                r_fill_cnt <= '0;
                r_out_addr <= '0;
                r_err      <= 1'b0;
            end

            if (r_state == S_HDR0) begin
                r_nrows <= 16'(sram_rd_data);
                r_kdim  <= 16'(wmem_rd_data);
            end

            if (r_state == S_HDR1) begin
                r_err <= !w_hdr_ok;
                if (w_hdr_ok) r_kernel <= wmem_rd_data[8:0];
            end

            if (w_issue_row)            r_rd_row   <= r_rd_row + 16'd1;
            if (r_state == S_FILL)      r_fill_cnt <= r_fill_cnt + 2'd1;
            if (w_accept && !w_last)    r_out_addr <= r_out_addr + ADDR_W'(1);
        end
    end

    row_window_buffer #(
        .DATA_W (DATA_W)
    ) u_row_window_buffer (
        .clk        (clk),
        .reset_b    (reset_b),
        .i_clear    (w_start),
        .i_fill     (r_state == S_FILL),
        .i_accept   (w_accept),
        .i_rd_valid (r_rd_pending),
        .i_rd_data  (sram_rd_data),
        .o_r0       (win_r0),
        .o_r1       (win_r1),
        .o_r2       (win_r2)
    );

    assign busy         = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done         = (r_state == S_DONE);
    assign err          = (r_state == S_DONE) && r_err;
    assign sram_rd_addr = w_sram_addr;
    assign wmem_rd_addr = w_wmem_addr;
    assign kernel       = r_kernel;
    assign kern_load    = r_kern_load;
    assign win_out_addr = r_out_addr;
    assign win_last     = w_last;
    assign win_valid    = (r_state == S_PRESENT);

endmodule
